ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 236 +++++++++++++++++++++++
 tb/tb_ex_stage.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : Execute stage of an in-order RV32I pipeline. Accepts one
//               instruction from ID per cycle through a valid/ack handshake,
//               evaluates the ALU, address, jump and branch logic, and
//               registers the result for MEM. A taken control transfer
//               raises a one-cycle branch_o pulse together with the redirect
//               target.
// Ports       :
//   clk              in   rising-edge clock
//   rstn_i           in   asynchronous active-low reset
//   halt_i           in   freeze every register while high
//   valid_i          in   ID->EX instruction valid
//   ack_o            out  instruction accepted this cycle (combinational)
//   instr_i/pc_i     in   instruction word and its PC
//   rs1_i/rs2_i      in   register operands
//   imm_i            in   decoded sign-extended immediate
//   ack_i            in   MEM consumed the current output this cycle
//   valid_o          out  EX->MEM output valid
//   instr_o/pc_o     out  registered instruction and PC
//   result_o         out  ALU result / address / link value
//   rs2_o            out  store data
//   branch_o         out  one-cycle control-transfer pulse
//   branch_target_o  out  redirect PC accompanying branch_o
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage #(
    parameter int BITSIZE = 32  // only 32 is supported
) (
    input  logic               clk,
    input  logic               rstn_i,
    input  logic               halt_i,
    input  logic               valid_i,
    output logic               ack_o,
    input  logic [BITSIZE-1:0] instr_i,
    input  logic [BITSIZE-1:0] pc_i,
    input  logic [BITSIZE-1:0] rs1_i,
    input  logic [BITSIZE-1:0] rs2_i,
    input  logic [BITSIZE-1:0] imm_i,
    input  logic               ack_i,
    output logic               valid_o,
    output logic [BITSIZE-1:0] instr_o,
    output logic [BITSIZE-1:0] result_o,
    output logic [BITSIZE-1:0] rs2_o,
    output logic [BITSIZE-1:0] pc_o,
    output logic               branch_o,
    output logic [BITSIZE-1:0] branch_target_o
);

    // ------------------------------------------------------------------
    // Opcodes
    // ------------------------------------------------------------------
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;

    // ALU funct3 encodings
    localparam logic [2:0] c_F3_ADD  = 3'b000;
    localparam logic [2:0] c_F3_SLL  = 3'b001;
    localparam logic [2:0] c_F3_SLT  = 3'b010;
    localparam logic [2:0] c_F3_SLTU = 3'b011;
    localparam logic [2:0] c_F3_XOR  = 3'b100;
    localparam logic [2:0] c_F3_SR   = 3'b101;
    localparam logic [2:0] c_F3_OR   = 3'b110;
    localparam logic [2:0] c_F3_AND  = 3'b111;

    // Branch funct3 encodings
    localparam logic [2:0] c_F3_BEQ  = 3'b000;
    localparam logic [2:0] c_F3_BNE  = 3'b001;
    localparam logic [2:0] c_F3_BLT  = 3'b100;
    localparam logic [2:0] c_F3_BGE  = 3'b101;
    localparam logic [2:0] c_F3_BLTU = 3'b110;
    localparam logic [2:0] c_F3_BGEU = 3'b111;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic               r_valid;
    logic [BITSIZE-1:0] r_instr;
    logic [BITSIZE-1:0] r_result;
    logic [BITSIZE-1:0] r_rs2;
    logic [BITSIZE-1:0] r_pc;
    logic               r_branch;
    logic [BITSIZE-1:0] r_target;

    // ------------------------------------------------------------------
    // Decode fields
    // ------------------------------------------------------------------
    logic [6:0]         w_opcode;
    logic [2:0]         w_funct3;
    logic               w_alt;
    logic               w_unused_instr_bits;

    assign w_opcode = instr_i[6:0];
    assign w_funct3 = instr_i[14:12];
    assign w_alt    = instr_i[30];

    // rd/rs fields are resolved upstream; keep them visibly unused.
    assign w_unused_instr_bits = &{1'b0, instr_i[BITSIZE-1:31], instr_i[29:15], instr_i[11:7]};

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic               w_accept;
    logic [BITSIZE-1:0] w_op_b;
    logic [4:0]         w_shamt;
    logic [BITSIZE-1:0] w_sum;
    logic [BITSIZE-1:0] w_diff;
    logic [BITSIZE-1:0] w_sra;
    logic               w_lt_s;
    logic               w_lt_u;
    logic               w_eq;
    logic [BITSIZE-1:0] w_addr;
    logic [BITSIZE-1:0] w_pc_imm;
    logic [BITSIZE-1:0] w_result;
    logic               w_taken;
    logic [BITSIZE-1:0] w_target;

    // Accept when a slot is free, or when MEM drains the current output in
    // the same cycle (back-to-back issue).
    assign w_accept = valid_i && !halt_i && (!r_valid || ack_i);
    assign ack_o    = w_accept;

    // Second operand is rs2 for register ALU ops and branch compares, the
    // immediate otherwise; the comparators are shared between SLT* and B*.
    assign w_op_b   = ((w_opcode == c_OPC_OP) || (w_opcode == c_OPC_BRANCH)) ? rs2_i : imm_i;
    assign w_shamt  = w_op_b[4:0];
    assign w_sum    = rs1_i + w_op_b;
    assign w_diff   = rs1_i - w_op_b;
    assign w_sra    = $signed(rs1_i) >>> w_shamt;
    assign w_lt_s   = $signed(rs1_i) < $signed(w_op_b);
    assign w_lt_u   = rs1_i < w_op_b;
    assign w_eq     = rs1_i == w_op_b;
    assign w_addr   = rs1_i + imm_i;
    assign w_pc_imm = pc_i + imm_i;

    always_comb begin
        w_result = '0;
        w_taken  = 1'b0;
        w_target = w_pc_imm;
        case (w_opcode)
            c_OPC_OP, c_OPC_OPIMM: begin
                case (w_funct3)
                    // bit 30 selects SUB only for the register form; ADDI ignores it
                    c_F3_ADD:  w_result = ((w_opcode == c_OPC_OP) && w_alt) ? w_diff : w_sum;
                    c_F3_SLL:  w_result = rs1_i << w_shamt;
                    c_F3_SLT:  w_result = {{(BITSIZE-1){1'b0}}, w_lt_s};
                    c_F3_SLTU: w_result = {{(BITSIZE-1){1'b0}}, w_lt_u};
                    c_F3_XOR:  w_result = rs1_i ^ w_op_b;
                    c_F3_SR:   w_result = w_alt ? w_sra : (rs1_i >> w_shamt);
                    c_F3_OR:   w_result = rs1_i | w_op_b;
                    c_F3_AND:  w_result = rs1_i & w_op_b;
                    default:   w_result = '0;
                endcase
            end
            c_OPC_LUI:   w_result = imm_i;
            c_OPC_AUIPC: w_result = w_pc_imm;
            c_OPC_LOAD,
            c_OPC_STORE: w_result = w_addr;
            c_OPC_JAL: begin
                w_result = pc_i;
                w_taken  = 1'b1;
            end
            c_OPC_JALR: begin
                w_result = pc_i;
                w_taken  = 1'b1;
                w_target = {w_addr[BITSIZE-1:1], 1'b0};
            end
            c_OPC_BRANCH: begin
                case (w_funct3)
                    c_F3_BEQ:  w_taken = w_eq;
                    c_F3_BNE:  w_taken = !w_eq;
                    c_F3_BLT:  w_taken = w_lt_s;
                    c_F3_BGE:  w_taken = !w_lt_s;
                    c_F3_BLTU: w_taken = w_lt_u;
                    c_F3_BGEU: w_taken = !w_lt_u;
                    default:   w_taken = 1'b0;
                endcase
            end
            default: begin
                w_result = '0;
                w_taken  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline register. halt_i freezes everything, including a pending
    // branch pulse, so the pulse is seen for exactly one non-halted cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_valid  <= 1'b0;
            r_instr  <= '0;
            r_result <= '0;
            r_rs2    <= '0;
            r_pc     <= '0;
            r_branch <= 1'b0;
            r_target <= '0;
        end else if (!halt_i) begin
            if (w_accept) begin
                r_valid  <= 1'b1;
                r_instr  <= instr_i;
                r_result <= w_result;
                r_rs2    <= rs2_i;
                r_pc     <= pc_i;
                r_branch <= w_taken;
                if (w_taken) begin
                    r_target <= w_target;
                end
            end else begin
                if (ack_i) begin
                    r_valid <= 1'b0;
                end
                r_branch <= 1'b0;
            end
        end
    end

    assign valid_o         = r_valid;
    assign instr_o         = r_instr;
    assign result_o        = r_result;
    assign rs2_o           = r_rs2;
    assign pc_o            = r_pc;
    assign branch_o        = r_branch;
    assign branch_target_o = r_target;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage
// Description : Self-checking bench for ex_stage. Expected results are
//               computed by a reference model when an instruction is
//               accepted, queued, and compared when the stage presents it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

    localparam logic [6:0] c_OP     = 7'b0110011;
    localparam logic [6:0] c_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_LUI    = 7'b0110111;
    localparam logic [6:0] c_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_LOAD   = 7'b0000011;
    localparam logic [6:0] c_STORE  = 7'b0100011;
    localparam logic [6:0] c_JAL    = 7'b1101111;
    localparam logic [6:0] c_JALR   = 7'b1100111;
    localparam logic [6:0] c_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] result;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic        br;
        logic [31:0] tgt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn_i;
    logic        halt_i;
    logic        valid_i;
    logic        ack_o;
    logic [31:0] instr_i, pc_i, rs1_i, rs2_i, imm_i;
    logic        ack_i;
    logic        valid_o;
    logic [31:0] instr_o, result_o, rs2_o, pc_o;
    logic        branch_o;
    logic [31:0] branch_target_o;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    ex_stage #(.BITSIZE(32)) dut (
        .clk             (clk),
        .rstn_i          (rstn_i),
        .halt_i          (halt_i),
        .valid_i         (valid_i),
        .ack_o           (ack_o),
        .instr_i         (instr_i),
        .pc_i            (pc_i),
        .rs1_i           (rs1_i),
        .rs2_i           (rs2_i),
        .imm_i           (imm_i),
        .ack_i           (ack_i),
        .valid_o         (valid_o),
        .instr_o         (instr_o),
        .result_o        (result_o),
        .rs2_o           (rs2_o),
        .pc_o            (pc_o),
        .branch_o        (branch_o),
        .branch_target_o (branch_target_o)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic b30);
        mk = {1'b0, b30, 5'd0, 5'd2, 5'd1, f3, 5'd3, op};
    endfunction

    // Reference model of the execute stage
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] r2,
                                   input logic [31:0] im);
        exp_t        e;
        logic [31:0] b;
        logic [2:0]  f3;
        logic        alt;
        f3  = ins[14:12];
        alt = ins[30];
        e.instr  = ins;
        e.pc     = pc;
        e.rs2    = r2;
        e.result = 32'd0;
        e.br     = 1'b0;
        e.tgt    = 32'd0;
        b = (ins[6:0] == c_OP) ? r2 : im;
        case (ins[6:0])
            c_OP, c_OPIMM: begin
                case (f3)
                    3'd0: e.result = (ins[6:0] == c_OP && alt) ? a - b : a + b;
                    3'd1: e.result = a << b[4:0];
                    3'd2: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd3: e.result = (a < b) ? 32'd1 : 32'd0;
                    3'd4: e.result = a ^ b;
                    3'd5: e.result = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
                    3'd6: e.result = a | b;
                    default: e.result = a & b;
                endcase
            end
            c_LUI:   e.result = im;
            c_AUIPC: e.result = pc + im;
            c_LOAD, c_STORE: e.result = a + im;
            c_JAL:   begin e.result = pc; e.br = 1'b1; e.tgt = pc + im; end
            c_JALR:  begin e.result = pc; e.br = 1'b1; e.tgt = (a + im) & 32'hFFFF_FFFE; end
            c_BRANCH: begin
                e.tgt = pc + im;
                case (f3)
                    3'd0: e.br = (a == r2);
                    3'd1: e.br = (a != r2);
                    3'd4: e.br = ($signed(a) < $signed(r2));
                    3'd5: e.br = ($signed(a) >= $signed(r2));
                    3'd6: e.br = (a < r2);
                    3'd7: e.br = (a >= r2);
                    default: e.br = 1'b0;
                endcase
            end
            default: ;
        endcase
        return e;
    endfunction

    // Drive one instruction with MEM ready, then compare the produced output
    // against the scoreboard head.
    task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] a,
                        input logic [31:0] r2, input logic [31:0] im);
        exp_t e;
        @(negedge clk);
        halt_i = 1'b0; ack_i = 1'b1; valid_i = 1'b1;
        instr_i = ins; pc_i = pc; rs1_i = a; rs2_i = r2; imm_i = im;
        #1;
        checks++;
        if (ack_o !== 1'b1) begin
            errors++; $display("FAIL send_ack instr=%h got %b exp 1", ins, ack_o);
        end
        sb.push_back(model(ins, pc, a, r2, im));
        @(posedge clk); #1;
        valid_i = 1'b0;
        checks++;
        if (sb.size() == 0) begin
            errors++; $display("FAIL send_scoreboard empty");
        end else begin
            e = sb.pop_front();
            if (valid_o !== 1'b1 || instr_o !== e.instr || result_o !== e.result ||
                rs2_o !== e.rs2 || pc_o !== e.pc || branch_o !== e.br ||
                (e.br && branch_target_o !== e.tgt)) begin
                errors++;
                $display("FAIL send_out instr=%h got v=%b res=%h rs2=%h pc=%h br=%b tgt=%h exp res=%h rs2=%h pc=%h br=%b tgt=%h",
                         e.instr, valid_o, result_o, rs2_o, pc_o, branch_o, branch_target_o,
                         e.result, e.rs2, e.pc, e.br, e.tgt);
            end
        end
    endtask

    task automatic test_reset;
        rstn_i = 1'b0; halt_i = 1'b0; valid_i = 1'b0; ack_i = 1'b0;
        instr_i = '0; pc_i = '0; rs1_i = '0; rs2_i = '0; imm_i = '0;
        #2;
        checks++;
        if ({valid_o, branch_o, instr_o, result_o, rs2_o, pc_o, branch_target_o} !== '0) begin
            errors++; $display("FAIL reset_outputs got v=%b br=%b res=%h exp 0", valid_o, branch_o, result_o);
        end
        repeat (3) @(negedge clk);
        rstn_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({valid_o, branch_o, ack_o} !== 3'b000) begin
            errors++; $display("FAIL reset_release got v=%b br=%b ack=%b exp 000", valid_o, branch_o, ack_o);
        end
    endtask

    task automatic test_addi;
        send(mk(c_OPIMM, 3'd0, 1'b1), 32'h40, 32'd5, 32'h0, 32'hFFFF_FFF9);
        checks++;
        if (result_o !== 32'hFFFF_FFFE || valid_o !== 1'b1) begin
            errors++; $display("FAIL addi_const got %h v=%b exp fffffffe v=1", result_o, valid_o);
        end
    endtask

    task automatic test_alu;
        send(mk(c_OP, 3'd5, 1'b1), 32'h44, 32'h8000_0000, 32'h24, 32'h0);
        checks++;
        if (result_o !== 32'hF800_0000) begin
            errors++; $display("FAIL sra_const got %h exp f8000000", result_o);
        end
        send(mk(c_OP, 3'd2, 1'b0), 32'h48, 32'h8000_0000, 32'd1, 32'h0);
        checks++;
        if (result_o !== 32'd1) begin
            errors++; $display("FAIL slt_const got %h exp 1", result_o);
        end
        send(mk(c_OP, 3'd3, 1'b0), 32'h4C, 32'h8000_0000, 32'd1, 32'h0);
        checks++;
        if (result_o !== 32'd0) begin
            errors++; $display("FAIL sltu_const got %h exp 0", result_o);
        end
        send(mk(c_OP, 3'd0, 1'b1), 32'h50, 32'd0, 32'd1, 32'h0);
        checks++;
        if (result_o !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL sub_wrap got %h exp ffffffff", result_o);
        end
        for (int f = 0; f < 8; f++) begin
            for (int alt = 0; alt < 2; alt++) begin
                send(mk(c_OP, 3'(f), 1'(alt)), $urandom, $urandom, $urandom, $urandom);
                send(mk(c_OPIMM, 3'(f), 1'(alt)), $urandom, $urandom, $urandom, $urandom);
            end
        end
    endtask

    task automatic test_branch;
        send(mk(c_BRANCH, 3'd6, 1'b0), 32'h100, 32'd1, 32'hFFFF_FFFF, 32'h20);
        checks++;
        if (branch_o !== 1'b1 || branch_target_o !== 32'h120 || result_o !== 32'd0) begin
            errors++; $display("FAIL bltu_const got br=%b tgt=%h res=%h exp 1 120 0", branch_o, branch_target_o, result_o);
        end
        @(negedge clk); valid_i = 1'b0; ack_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (branch_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++; $display("FAIL branch_pulse_drop got br=%b v=%b exp 0 0", branch_o, valid_o);
        end
        send(mk(c_BRANCH, 3'd4, 1'b0), 32'h100, 32'd1, 32'hFFFF_FFFF, 32'h20);
        checks++;
        if (branch_o !== 1'b0) begin
            errors++; $display("FAIL blt_const got br=%b exp 0", branch_o);
        end
        for (int f = 0; f < 8; f++) begin
            logic [31:0] x;
            x = $urandom;
            send(mk(c_BRANCH, 3'(f), 1'b0), $urandom, x, x, $urandom);
            send(mk(c_BRANCH, 3'(f), 1'b0), $urandom, 32'h8000_0000, 32'h7FFF_FFFF, $urandom);
            send(mk(c_BRANCH, 3'(f), 1'b0), $urandom, $urandom, $urandom, $urandom);
        end
    endtask

    task automatic test_other_ops;
        send(mk(c_LUI,   3'd0, 1'b0), 32'h200, $urandom, $urandom, 32'hABCD_E000);
        send(mk(c_AUIPC, 3'd0, 1'b0), 32'hFFFF_FF00, $urandom, $urandom, 32'h0000_0200);
        send(mk(c_LOAD,  3'd2, 1'b0), 32'h204, 32'hFFFF_FFFC, $urandom, 32'h8);
        send(mk(c_STORE, 3'd2, 1'b0), 32'h208, 32'h1000, 32'hDEAD_BEEF, 32'hFFFF_FFF0);
        send(mk(c_JAL,   3'd0, 1'b0), 32'h20C, $urandom, $urandom, 32'hFFFF_FFF4);
        send(mk(c_JALR,  3'd0, 1'b0), 32'h210, 32'h3001, $urandom, 32'h2);
        send(mk(7'h7F,   3'd5, 1'b1), 32'h214, $urandom, $urandom, $urandom);
        checks++;
        if (result_o !== 32'd0 || branch_o !== 1'b0) begin
            errors++; $display("FAIL illegal_op got res=%h br=%b exp 0 0", result_o, branch_o);
        end
        send(mk(7'h0F,   3'd0, 1'b0), 32'h218, $urandom, $urandom, $urandom);
    endtask

    task automatic test_stall;
        logic [31:0] ia, ib;
        exp_t ea;
        ia = mk(c_OP, 3'd4, 1'b0);
        ib = mk(c_OPIMM, 3'd6, 1'b0);
        @(negedge clk);
        halt_i = 1'b0; ack_i = 1'b1; valid_i = 1'b1;
        instr_i = ia; pc_i = 32'h300; rs1_i = 32'h0F0F_0F0F; rs2_i = 32'hFFFF_0000; imm_i = 32'h5;
        #1;
        checks++;
        if (ack_o !== 1'b1) begin
            errors++; $display("FAIL stall_first_ack got %b exp 1", ack_o);
        end
        sb.push_back(model(ia, 32'h300, 32'h0F0F_0F0F, 32'hFFFF_0000, 32'h5));
        @(posedge clk); #1;
        ack_i = 1'b0;
        instr_i = ib; pc_i = 32'h304; rs1_i = 32'h1200; rs2_i = 32'h77; imm_i = 32'h0034;
        #1;
        checks++;
        if (ack_o !== 1'b0) begin
            errors++; $display("FAIL stall_ack_blocked got %b exp 0", ack_o);
        end
        ea = sb[0];
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (valid_o !== 1'b1 || instr_o !== ea.instr || result_o !== ea.result ||
                pc_o !== ea.pc || rs2_o !== ea.rs2 || ack_o !== 1'b0) begin
                errors++; $display("FAIL stall_hold got v=%b res=%h pc=%h ack=%b exp res=%h pc=%h",
                                   valid_o, result_o, pc_o, ack_o, ea.result, ea.pc);
            end
        end
        void'(sb.pop_front());
        @(negedge clk);
        ack_i = 1'b1;
        #1;
        checks++;
        if (ack_o !== 1'b1) begin
            errors++; $display("FAIL stall_release_ack got %b exp 1", ack_o);
        end
        sb.push_back(model(ib, 32'h304, 32'h1200, 32'h77, 32'h0034));
        @(posedge clk); #1;
        valid_i = 1'b0;
        ea = sb.pop_front();
        checks++;
        if (valid_o !== 1'b1 || instr_o !== ea.instr || result_o !== ea.result || pc_o !== ea.pc) begin
            errors++; $display("FAIL stall_next got res=%h pc=%h exp res=%h pc=%h", result_o, pc_o, ea.result, ea.pc);
        end
        @(posedge clk); #1;
        checks++;
        if (valid_o !== 1'b0) begin
            errors++; $display("FAIL drain_valid got %b exp 0", valid_o);
        end
    endtask

    task automatic test_halt_reset;
        send(mk(c_JALR, 3'd0, 1'b0), 32'h2000, 32'h1003, 32'h0, 32'h0);
        halt_i = 1'b1; valid_i = 1'b1; instr_i = mk(c_OP, 3'd0, 1'b0);
        #1;
        checks++;
        if (ack_o !== 1'b0) begin
            errors++; $display("FAIL halt_ack got %b exp 0", ack_o);
        end
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (branch_o !== 1'b1 || branch_target_o !== 32'h1002 || valid_o !== 1'b1 || result_o !== 32'h2000) begin
                errors++; $display("FAIL halt_hold got br=%b tgt=%h v=%b res=%h exp 1 1002 1 2000",
                                   branch_o, branch_target_o, valid_o, result_o);
            end
        end
        @(negedge clk);
        halt_i = 1'b0; valid_i = 1'b0; ack_i = 1'b1;
        #1;
        checks++;
        if (branch_o !== 1'b1) begin
            errors++; $display("FAIL halt_release_pulse got %b exp 1", branch_o);
        end
        @(posedge clk); #1;
        checks++;
        if (branch_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++; $display("FAIL halt_after_drop got br=%b v=%b exp 0 0", branch_o, valid_o);
        end
        send(mk(c_JAL, 3'd0, 1'b0), 32'h500, 32'h0, 32'h1234, 32'h40);
        #2;
        rstn_i = 1'b0;
        #1;
        checks++;
        if ({valid_o, branch_o, instr_o, result_o, rs2_o, pc_o, branch_target_o} !== '0) begin
            errors++; $display("FAIL midreset got v=%b br=%b res=%h pc=%h tgt=%h exp 0",
                               valid_o, branch_o, result_o, pc_o, branch_target_o);
        end
        @(negedge clk);
        rstn_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (valid_o !== 1'b0 || branch_o !== 1'b0) begin
            errors++; $display("FAIL midreset_release got v=%b br=%b exp 0 0", valid_o, branch_o);
        end
        sb.delete();
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 12; i++) begin
            logic [6:0] op;
            case (i % 4)
                0: op = c_OP;
                1: op = c_OPIMM;
                2: op = c_BRANCH;
                default: op = c_JAL;
            endcase
            send(mk(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))),
                 $urandom, $urandom, $urandom, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_alu();
        test_branch();
        test_other_ops();
        test_stall();
        test_halt_reset();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
